// File: rtl/cordic_phase_front.sv
// cordic_phase_front: phase accumulator with quadrant fold/un-fold around a 16-bit CORDIC sin/cos core.
// Define PHASE_FRONT_NEG_SAT_EN to make un-fold negations saturate (-(-32768) = 32767).
module cordic_phase_front #(
    parameter int          CORDIC_LAT = 16,
    parameter logic [15:0] XINIT      = 16'd9949,
    parameter logic [15:0] HALF_PI    = 16'd25736
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               en,
    input  logic               load,
    input  logic        [15:0] phase_in,
    input  logic        [15:0] step,
    output logic        [15:0] angle,
    output logic        [15:0] Xin,
    output logic        [15:0] Yin,
    input  logic signed [15:0] cos_raw,
    input  logic signed [15:0] sin_raw,
    output logic signed [15:0] cos_out,
    output logic signed [15:0] sin_out,
    output logic               valid
);
    logic        [15:0]             r_acc;
    logic        [15:0]             r_angle;
    logic        [CORDIC_LAT:0][2:0] r_tag;
    logic signed [15:0]             r_cos;
    logic signed [15:0]             r_sin;
    logic                           r_valid;
    logic                           w_issue;
    logic        [29:0]             w_prod;
    logic        [2:0]              w_tail;
    logic signed [15:0]             w_cos;
    logic signed [15:0]             w_sin;

    function automatic logic signed [15:0] neg(input logic signed [15:0] x);
`ifdef PHASE_FRONT_NEG_SAT_EN
        return (x == 16'sh8000) ? 16'sh7fff : -x;
`else
        return -x;
`endif
    endfunction

    assign w_issue = en & ~load;
    assign w_prod  = 30'(r_acc[13:0]) * 30'(HALF_PI);
    assign w_tail  = r_tag[CORDIC_LAT];

    // Tail tag {valid, q} lines up with the core output for the sample it describes
    always_comb begin
        w_cos = (w_tail[1:0] == 2'd0) ? cos_raw :
                (w_tail[1:0] == 2'd1) ? neg(sin_raw) :
                (w_tail[1:0] == 2'd2) ? neg(cos_raw) : sin_raw;
        w_sin = (w_tail[1:0] == 2'd0) ? sin_raw :
                (w_tail[1:0] == 2'd1) ? cos_raw :
                (w_tail[1:0] == 2'd2) ? neg(sin_raw) : neg(cos_raw);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_acc   <= '0;
            r_angle <= '0;
            r_tag   <= '0;
            r_cos   <= '0;
            r_sin   <= '0;
            r_valid <= 1'b0;
        end else begin
            r_tag   <= {r_tag[CORDIC_LAT-1:0], w_issue, r_acc[15:14]};
            r_valid <= w_tail[2];
            if (load)
                r_acc <= phase_in;
            else if (en) begin
                r_acc   <= r_acc + step;
                r_angle <= w_prod[29:14];
            end
            if (w_tail[2]) begin
                r_cos <= w_cos;
                r_sin <= w_sin;
            end
        end
    end

    assign angle   = r_angle;
    assign Xin     = XINIT;
    assign Yin     = '0;
    assign cos_out = r_cos;
    assign sin_out = r_sin;
    assign valid   = r_valid;
endmodule
